// File: rtl/core_load_run_checker.sv
// Load-run-check sequencer: streams an image into core storage, presses START,
// waits for program stop (with timeout), then verifies sign-magnitude ordering of a region.
module core_load_run_checker #(
    parameter int unsigned WORD_W    = 36,
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned PRESS_CYC = 1000,
    parameter int unsigned TIMEOUT_W = 24
) (
    input  logic                 CL,
    input  logic                 RESET,
    input  logic                 go,
    input  logic [1:0]           mode,
    input  logic [ADDR_W-1:0]    chk_base,
    input  logic [ADDR_W-1:0]    chk_len,
    input  logic [TIMEOUT_W-1:0] timeout_lim,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [ADDR_W-1:0]    ld_addr,
    input  logic [WORD_W-1:0]    ld_data,
    input  logic                 ld_last,
    output logic                 mem_we,
    output logic                 mem_re,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [WORD_W-1:0]    mem_wdata,
    input  logic [WORD_W-1:0]    mem_rdata,
    output logic                 start_button,
    input  logic                 prog_stop,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timed_out,
    output logic [ADDR_W-1:0]    fail_addr,
    output logic [TIMEOUT_W-1:0] run_cycles
);

    localparam int unsigned PCW = $clog2(PRESS_CYC + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StPress,
        StRun,
        StRead,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             mode_q, mode_d;
    logic [ADDR_W-1:0]      base_q, base_d;
    logic [ADDR_W-1:0]      len_q, len_d;
    logic [TIMEOUT_W-1:0]   lim_q, lim_d;
    logic [PCW-1:0]         press_q, press_d;
    logic                   start_q, start_d;
    logic [TIMEOUT_W-1:0]   run_q, run_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic                   to_q, to_d;
    logic [ADDR_W-1:0]      fail_q, fail_d;
    logic                   re_q, re_d;
    logic [ADDR_W-1:0]      raddr_q, raddr_d;
    logic [ADDR_W-1:0]      iss_q, iss_d;
    logic                   rvalid_q, rvalid_d;
    logic [ADDR_W-1:0]      vaddr_q, vaddr_d;
    logic [ADDR_W-1:0]      rcv_q, rcv_d;
    logic [WORD_W-1:0]      prev_q, prev_d;
    logic                   pair_ok;
    logic                   more_rd;

    // True when a < b in sign-magnitude; -0 is treated as +0.
    function automatic logic sm_lt(input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b);
        logic [WORD_W-2:0] am;
        logic [WORD_W-2:0] bm;
        logic              an;
        logic              bn;
        am = a[WORD_W-2:0];
        bm = b[WORD_W-2:0];
        an = a[WORD_W-1] && (am != '0);
        bn = b[WORD_W-1] && (bm != '0);
        if (an != bn) begin
            sm_lt = an;
        end else if (an) begin
            sm_lt = am > bm;
        end else begin
            sm_lt = am < bm;
        end
    endfunction

    always_comb begin
        pair_ok = 1'b1;
        case (mode_q)
            2'd1:    pair_ok = !sm_lt(mem_rdata, prev_q);
            2'd2:    pair_ok = !sm_lt(prev_q, mem_rdata);
            2'd3:    pair_ok = sm_lt(prev_q, mem_rdata);
            default: pair_ok = 1'b1;
        endcase
    end

    assign more_rd = ({1'b0, iss_q} + (ADDR_W + 1)'(1)) < {1'b0, len_q};

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        base_d   = base_q;
        len_d    = len_q;
        lim_d    = lim_q;
        press_d  = press_q;
        start_d  = start_q;
        run_d    = run_q;
        done_d   = done_q;
        pass_d   = pass_q;
        to_d     = to_q;
        fail_d   = fail_q;
        re_d     = re_q;
        raddr_d  = raddr_q;
        iss_d    = iss_q;
        rcv_d    = rcv_q;
        prev_d   = prev_q;
        rvalid_d = re_q;
        vaddr_d  = raddr_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (go) begin
                    state_d = StLoad;
                    mode_d  = mode;
                    base_d  = chk_base;
                    len_d   = chk_len;
                    lim_d   = timeout_lim;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    to_d    = 1'b0;
                    fail_d  = '0;
                    run_d   = '0;
                end
            end
            StLoad: begin
                if (ld_valid && ld_last) begin
                    state_d = StPress;
                    start_d = 1'b1;
                    press_d = '0;
                end
            end
            StPress: begin
                if (press_q == PCW'(PRESS_CYC - 1)) begin
                    state_d = StRun;
                    start_d = 1'b0;
                end else begin
                    press_d = press_q + PCW'(1);
                end
            end
            StRun: begin
                run_d = (&run_q) ? run_q : run_q + TIMEOUT_W'(1);
                if (prog_stop) begin
                    if (mode_q == 2'd0 || len_q < ADDR_W'(2)) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = StRead;
                        re_d    = 1'b1;
                        raddr_d = base_q;
                        iss_d   = '0;
                        rcv_d   = '0;
                    end
                end else if (run_d == lim_q) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    to_d    = 1'b1;
                    pass_d  = 1'b0;
                end
            end
            StRead: begin
                if (re_q) begin
                    if (more_rd) begin
                        raddr_d = raddr_q + ADDR_W'(1);
                        iss_d   = iss_q + ADDR_W'(1);
                    end else begin
                        re_d = 1'b0;
                    end
                end
                // Word k arrives one cycle after its read; word 0 only seeds prev.
                if (rvalid_q) begin
                    prev_d = mem_rdata;
                    rcv_d  = rcv_q + ADDR_W'(1);
                    if (rcv_q != '0 && !pair_ok) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        pass_d  = 1'b0;
                        fail_d  = vaddr_q;
                        re_d    = 1'b0;
                    end else if (rcv_q == len_q - ADDR_W'(1)) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                        re_d    = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CL) begin
        if (RESET) begin
            state_q  <= StIdle;
            mode_q   <= '0;
            base_q   <= '0;
            len_q    <= '0;
            lim_q    <= '0;
            press_q  <= '0;
            start_q  <= 1'b0;
            run_q    <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            to_q     <= 1'b0;
            fail_q   <= '0;
            re_q     <= 1'b0;
            raddr_q  <= '0;
            iss_q    <= '0;
            rvalid_q <= 1'b0;
            vaddr_q  <= '0;
            rcv_q    <= '0;
            prev_q   <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            base_q   <= base_d;
            len_q    <= len_d;
            lim_q    <= lim_d;
            press_q  <= press_d;
            start_q  <= start_d;
            run_q    <= run_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            to_q     <= to_d;
            fail_q   <= fail_d;
            re_q     <= re_d;
            raddr_q  <= raddr_d;
            iss_q    <= iss_d;
            rvalid_q <= rvalid_d;
            vaddr_q  <= vaddr_d;
            rcv_q    <= rcv_d;
            prev_q   <= prev_d;
        end
    end

    // Write side is a same-cycle pass-through of the accepted load word.
    assign ld_ready     = (state_q == StLoad);
    assign mem_we       = ld_ready && ld_valid;
    assign mem_re       = re_q;
    assign mem_addr     = mem_we ? ld_addr : (re_q ? raddr_q : '0);
    assign mem_wdata    = mem_we ? ld_data : '0;
    assign start_button = start_q;
    assign busy         = (state_q != StIdle) && (state_q != StDone);
    assign done         = done_q;
    assign pass         = pass_q;
    assign timed_out    = to_q;
    assign fail_addr    = fail_q;
    assign run_cycles   = run_q;

endmodule

// File: tb/tb_core_load_run_checker.sv
// Directed bench for core_load_run_checker with a storage model and write/read scoreboards.
module tb_core_load_run_checker;

    localparam int WW = 36;
    localparam int AW = 15;
    localparam int PC = 1000;
    localparam int TW = 24;

    logic          CL = 1'b0;
    logic          RESET = 1'b1;
    logic          go = 1'b0;
    logic [1:0]    mode = '0;
    logic [AW-1:0] chk_base = '0;
    logic [AW-1:0] chk_len = '0;
    logic [TW-1:0] timeout_lim = '0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [AW-1:0] ld_addr = '0;
    logic [WW-1:0] ld_data = '0;
    logic          ld_last = 1'b0;
    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_wdata;
    logic [WW-1:0] mem_rdata = '0;
    logic          start_button;
    logic          prog_stop = 1'b0;
    logic          busy;
    logic          done;
    logic          pass;
    logic          timed_out;
    logic [AW-1:0] fail_addr;
    logic [TW-1:0] run_cycles;

    core_load_run_checker #(
        .WORD_W(WW), .ADDR_W(AW), .PRESS_CYC(PC), .TIMEOUT_W(TW)
    ) dut (
        .CL(CL), .RESET(RESET), .go(go), .mode(mode), .chk_base(chk_base),
        .chk_len(chk_len), .timeout_lim(timeout_lim), .ld_valid(ld_valid),
        .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .start_button(start_button), .prog_stop(prog_stop),
        .busy(busy), .done(done), .pass(pass), .timed_out(timed_out),
        .fail_addr(fail_addr), .run_cycles(run_cycles)
    );

    always #5 CL = ~CL;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [WW-1:0] d;
    } xact_t;
    xact_t wr_q[$];
    xact_t rd_q[$];

    logic [WW-1:0] mem [0:(1<<AW)-1];
    logic [WW-1:0] sort_val [10];
    logic          do_sort = 1'b0;

    // Storage model; do_sort stands in for the 704 sort program running.
    always @(posedge CL) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (do_sort) begin
            for (int i = 0; i < 10; i++) mem[15 + i] <= sort_val[i];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge CL) begin
        if (mem_we && mem_re) check("we_re_excl", 64'(mem_re), 64'd0);
        if (mem_we) begin
            wr_cnt++;
            total++;
            assert (wr_q.size() > 0) else begin
                bad++;
                $error("FAIL wr_extra: observed write @%0o expected none", mem_addr);
            end
            if (wr_q.size() > 0) begin
                xact_t e;
                e = wr_q.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e.a));
                check("wr_data", 64'(mem_wdata), 64'(e.d));
            end
        end
        if (mem_re) begin
            rd_cnt++;
            total++;
            assert (rd_q.size() > 0) else begin
                bad++;
                $error("FAIL rd_extra: observed read @%0o expected none", mem_addr);
            end
            if (rd_q.size() > 0) begin
                xact_t e;
                e = rd_q.pop_front();
                check("rd_addr", 64'(mem_addr), 64'(e.a));
                check("rd_word", 64'(mem[mem_addr]), 64'(e.d));
            end
        end
    end

    task automatic tick();
        @(posedge CL);
        #1;
    endtask

    task automatic start_seq(input logic [1:0] m, input int base, input int len, input int lim);
        mode = m;
        chk_base = AW'(base);
        chk_len = AW'(len);
        timeout_lim = TW'(lim);
        go = 1'b1;
        tick();
        go = 1'b0;
        check("go_busy", 64'(busy), 64'd1);
        check("go_done_clr", 64'(done), 64'd0);
        check("go_pass_clr", 64'(pass), 64'd0);
    endtask

    task automatic load_word(input int a, input logic [WW-1:0] d, input bit last, input bit gap);
        int n;
        if (gap) begin
            ld_valid = 1'b0;
            tick();
        end
        ld_valid = 1'b1;
        ld_addr = AW'(a);
        ld_data = d;
        ld_last = last;
        n = 0;
        while (!ld_ready && n < 20) begin
            tick();
            n++;
        end
        total++;
        assert (ld_ready) else begin
            bad++;
            $error("FAIL ld_ready: observed 0 expected 1");
        end
        wr_q.push_back('{a: AW'(a), d: d});
        tick();
        ld_valid = 1'b0;
        ld_last = 1'b0;
    endtask

    task automatic press_wait(output int n);
        n = 0;
        check("press_start", 64'(start_button), 64'd1);
        while (start_button && n < 3000) begin
            tick();
            n++;
        end
        check("press_len", 64'(n), 64'(PC));
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 5000) begin
            tick();
            n++;
        end
        total++;
        assert (done) else begin
            bad++;
            $error("FAIL done_wait: observed done=0 after %0d cycles expected 1", n);
        end
    endtask

    task automatic push_rd(input int a, input logic [WW-1:0] d);
        rd_q.push_back('{a: AW'(a), d: d});
    endtask

    int            n;
    int            rc;
    int            wsnap;
    int            rsnap;
    logic [WW-1:0] img [10];
    logic [WW-1:0] sgn [4];
    logic [WW-1:0] tmp;

    initial begin
        img = '{36'd2334, 36'd4, 36'd193, 36'd2482, 36'd8,
                36'd99, 36'd2211, 36'd34, 36'd321, 36'd123};
        sgn = '{{1'b1, 35'd7}, 36'd0, {1'b1, 35'd0}, 36'd2};

        // Reset state
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_start", 64'(start_button), 64'd0);
        check("rst_ld_ready", 64'(ld_ready), 64'd0);
        check("rst_mem_re", 64'(mem_re), 64'd0);
        check("rst_run", 64'(run_cycles), 64'd0);
        RESET = 1'b0;
        tick();

        // Sort program image: 25 words 000..030, result region 017..030
        for (int i = 0; i < 10; i++) sort_val[i] = img[i];
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 9 - i; j++) begin
                if (sort_val[j] > sort_val[j + 1]) begin
                    tmp = sort_val[j];
                    sort_val[j] = sort_val[j + 1];
                    sort_val[j + 1] = tmp;
                end
            end
        end
        start_seq(2'd1, 'o17, 10, 100000);
        for (int i = 0; i < 25; i++) begin
            load_word(i, (i < 15) ? (36'o050000000000 + WW'(i)) : img[i - 15], i == 24, 1'b0);
        end
        for (int i = 0; i < 10; i++) push_rd('o17 + i, sort_val[i]);
        press_wait(n);
        rc = 1;
        do_sort = 1'b1;
        tick();
        rc++;
        do_sort = 1'b0;
        repeat (20) begin
            tick();
            rc++;
        end
        prog_stop = 1'b1;
        tick();
        prog_stop = 1'b0;
        wait_done(n);
        check("sort_pass", 64'(pass), 64'd1);
        check("sort_timed_out", 64'(timed_out), 64'd0);
        check("sort_run_cycles", 64'(run_cycles), 64'(rc));
        check("sort_reads_left", 64'(rd_q.size()), 64'd0);
        check("sort_busy", 64'(busy), 64'd0);

        // Unsorted pair, program stop already lit
        prog_stop = 1'b1;
        start_seq(2'd1, 'o100, 2, 100000);
        load_word('o100, 36'd5, 1'b0, 1'b0);
        load_word('o101, 36'd3, 1'b1, 1'b0);
        push_rd('o100, 36'd5);
        push_rd('o101, 36'd3);
        press_wait(n);
        wait_done(n);
        check("unsorted_pass", 64'(pass), 64'd0);
        check("unsorted_fail_addr", 64'(fail_addr), 64'o101);
        check("unsorted_reads_left", 64'(rd_q.size()), 64'd0);

        // Sign-magnitude: -7, +0, -0, +2 ascending
        start_seq(2'd1, 'o200, 4, 100000);
        for (int i = 0; i < 4; i++) load_word('o200 + i, sgn[i], i == 3, 1'b0);
        for (int i = 0; i < 4; i++) push_rd('o200 + i, sgn[i]);
        press_wait(n);
        wait_done(n);
        check("sign_asc_pass", 64'(pass), 64'd1);
        check("sign_asc_reads_left", 64'(rd_q.size()), 64'd0);

        // Same words strictly ascending: -0 equals +0 at the third word
        start_seq(2'd3, 'o200, 4, 100000);
        for (int i = 0; i < 4; i++) load_word('o200 + i, sgn[i], i == 3, 1'b0);
        for (int i = 0; i < 4; i++) push_rd('o200 + i, sgn[i]);
        press_wait(n);
        wait_done(n);
        check("sign_strict_pass", 64'(pass), 64'd0);
        check("sign_strict_fail_addr", 64'(fail_addr), 64'o202);
        check("sign_strict_reads", 64'(rd_q.size() <= 1), 64'd1);
        rd_q.delete();

        // Timeout with no program stop
        prog_stop = 1'b0;
        start_seq(2'd1, 'o100, 2, 50);
        load_word('o100, 36'd1, 1'b0, 1'b0);
        load_word('o101, 36'd2, 1'b1, 1'b0);
        rsnap = rd_cnt;
        press_wait(n);
        wait_done(n);
        check("to_latency", 64'(n), 64'd50);
        check("to_timed_out", 64'(timed_out), 64'd1);
        check("to_run_cycles", 64'(run_cycles), 64'd50);
        check("to_pass", 64'(pass), 64'd0);
        check("to_no_reads", 64'(rd_cnt - rsnap), 64'd0);

        // Program stop on the exact timeout cycle wins
        start_seq(2'd1, 'o100, 2, 50);
        load_word('o100, 36'd1, 1'b0, 1'b0);
        load_word('o101, 36'd2, 1'b1, 1'b0);
        push_rd('o100, 36'd1);
        push_rd('o101, 36'd2);
        press_wait(n);
        repeat (49) tick();
        prog_stop = 1'b1;
        tick();
        prog_stop = 1'b0;
        wait_done(n);
        check("edge_timed_out", 64'(timed_out), 64'd0);
        check("edge_pass", 64'(pass), 64'd1);
        check("edge_run_cycles", 64'(run_cycles), 64'd50);
        check("edge_reads_left", 64'(rd_q.size()), 64'd0);

        // Backpressure, go ignored while busy, then abort in PRESS
        wsnap = wr_cnt;
        start_seq(2'd1, 'o300, 4, 100000);
        for (int i = 0; i < 4; i++) load_word('o300 + i, 36'd1000 + WW'(i * 7), i == 3, 1'b1);
        check("bp_writes", 64'(wr_cnt - wsnap), 64'd4);
        repeat (10) tick();
        go = 1'b1;
        tick();
        go = 1'b0;
        check("press_go_ignored", 64'(start_button), 64'd1);
        check("press_busy", 64'(busy), 64'd1);
        RESET = 1'b1;
        tick();
        check("abort_start", 64'(start_button), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        RESET = 1'b0;
        wsnap = wr_cnt;
        repeat (5) tick();
        check("abort_no_writes", 64'(wr_cnt - wsnap), 64'd0);

        // Address wrap, then rerun with a second go
        prog_stop = 1'b1;
        for (int r = 0; r < 2; r++) begin
            start_seq(2'd1, (1 << AW) - 1, 3, 100000);
            load_word((1 << AW) - 1, 36'd10, 1'b0, 1'b0);
            load_word(0, 36'd20, 1'b0, 1'b0);
            load_word(1, 36'd30, 1'b1, 1'b0);
            push_rd((1 << AW) - 1, 36'd10);
            push_rd(0, 36'd20);
            push_rd(1, 36'd30);
            press_wait(n);
            wait_done(n);
            check("wrap_pass", 64'(pass), 64'd1);
            check("wrap_reads_left", 64'(rd_q.size()), 64'd0);
        end
        prog_stop = 1'b0;
        check("final_writes_left", 64'(wr_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
